// File: rtl/stuff_or_data_demapper_if.sv
// rtl/stuff_or_data_demapper_if.sv - payload stream in, extracted client data and status out
// master drives the payload side (frame-overhead parser), slave is the demapper.
interface stuff_or_data_demapper_if #(
  parameter int MPT_W  = 8,
  parameter int DATA_W = 8
);
  logic [MPT_W-1:0]  pm;
  logic [MPT_W-1:0]  cm;
  logic              valid_in;
  logic              sof;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              sof_out;
  logic              ds;
  logic              frame_done;
  logic              err_sof_early;
  logic              err_sof_late;
  logic              err_cfg;

  modport master (
    output pm, cm, valid_in, sof, din,
    input  dout, dout_valid, sof_out, ds, frame_done,
           err_sof_early, err_sof_late, err_cfg
  );

  modport slave (
    input  pm, cm, valid_in, sof, din,
    output dout, dout_valid, sof_out, ds, frame_done,
           err_sof_early, err_sof_late, err_cfg
  );
endinterface

// File: rtl/stuff_or_data_demapper.sv
// rtl/stuff_or_data_demapper.sv - sigma-delta stuff/data demapper with frame alignment checks
// Regenerates the transmitter's per-position decision from latched pm/cm and forwards data words only.
module stuff_or_data_demapper #(
  parameter int MPT_W  = 8,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  stuff_or_data_demapper_if.slave bus
);
  typedef enum logic {IDLE, FRAME} state_t;

  state_t            state, state_n;
  logic [MPT_W-1:0]  pos, pos_n;
  logic [MPT_W:0]    acc, acc_n;
  logic [MPT_W-1:0]  pm_l, pm_n;
  logic [MPT_W-1:0]  cm_l, cm_n;
  logic              first, first_n;
  logic [DATA_W-1:0] dout_r, dout_n;
  logic              ds_r, ds_n;
  logic              dv_r, dv_n;
  logic              sofo_r, sofo_n;
  logic              fd_r, fd_n;
  logic              early_r, early_n;
  logic              late_r, late_n;
  logic              cfg_r, cfg_n;

  logic              cfg_ok;
  logic              decide;
  logic              first_use;
  logic [MPT_W-1:0]  pm_use, cm_use, pos_use;
  logic [MPT_W:0]    acc_base, s;

  assign cfg_ok = (bus.pm != '0) && (bus.cm <= bus.pm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= '0;
      acc     <= '0;
      pm_l    <= '0;
      cm_l    <= '0;
      first   <= 1'b0;
      dout_r  <= '0;
      ds_r    <= 1'b0;
      dv_r    <= 1'b0;
      sofo_r  <= 1'b0;
      fd_r    <= 1'b0;
      early_r <= 1'b0;
      late_r  <= 1'b0;
      cfg_r   <= 1'b0;
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      acc     <= acc_n;
      pm_l    <= pm_n;
      cm_l    <= cm_n;
      first   <= first_n;
      dout_r  <= dout_n;
      ds_r    <= ds_n;
      dv_r    <= dv_n;
      sofo_r  <= sofo_n;
      fd_r    <= fd_n;
      early_r <= early_n;
      late_r  <= late_n;
      cfg_r   <= cfg_n;
    end
  end

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    acc_n     = acc;
    pm_n      = pm_l;
    cm_n      = cm_l;
    first_n   = first;
    dout_n    = dout_r;
    ds_n      = ds_r;
    dv_n      = 1'b0;
    sofo_n    = 1'b0;
    fd_n      = 1'b0;
    early_n   = 1'b0;
    late_n    = 1'b0;
    cfg_n     = 1'b0;
    decide    = 1'b0;
    first_use = first;
    pm_use    = pm_l;
    cm_use    = cm_l;
    acc_base  = acc;
    pos_use   = pos + 1'b1;
    s         = '0;

    if (bus.valid_in) begin
      if (bus.sof) begin
        // Any sof inside a frame abandons it, even when the new config is rejected.
        early_n = (state == FRAME);
        if (!cfg_ok) begin
          cfg_n   = 1'b1;
          state_n = IDLE;
        end else begin
          decide    = 1'b1;
          pm_use    = bus.pm;
          cm_use    = bus.cm;
          pm_n      = bus.pm;
          cm_n      = bus.cm;
          acc_base  = '0;
          pos_use   = {{(MPT_W-1){1'b0}}, 1'b1};
          first_use = 1'b1;
        end
      end else if (state == FRAME) begin
        decide = 1'b1;
      end else begin
        late_n = 1'b1;
      end
    end

    if (decide) begin
      s     = acc_base + {1'b0, cm_use};
      ds_n  = (s >= {1'b0, pm_use});
      acc_n = ds_n ? (s - {1'b0, pm_use}) : s;
      pos_n = pos_use;
      if (ds_n) begin
        dout_n = bus.din;
        dv_n   = 1'b1;
        sofo_n = first_use;
      end
      first_n = first_use && !ds_n;
      if (pos_use == pm_use) begin
        fd_n    = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = FRAME;
      end
    end
  end

  assign bus.dout          = dout_r;
  assign bus.ds            = ds_r;
  assign bus.dout_valid    = dv_r;
  assign bus.sof_out       = sofo_r;
  assign bus.frame_done    = fd_r;
  assign bus.err_sof_early = early_r;
  assign bus.err_sof_late  = late_r;
  assign bus.err_cfg       = cfg_r;
endmodule

// File: tb/tb_stuff_or_data_demapper.sv
// tb/tb_stuff_or_data_demapper.sv - directed self-checking bench for stuff_or_data_demapper
// Flag vector order: {ds, dout_valid, sof_out, frame_done, err_sof_early, err_sof_late, err_cfg}.
module tb_stuff_or_data_demapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ds   = 1'b0;

  stuff_or_data_demapper_if #(.MPT_W(8), .DATA_W(8)) bus ();

  stuff_or_data_demapper #(.MPT_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] flags();
    return {bus.ds, bus.dout_valid, bus.sof_out, bus.frame_done,
            bus.err_sof_early, bus.err_sof_late, bus.err_cfg};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [7:0] d,
                      input logic [6:0] exp_flags, input logic [7:0] exp_d);
    bus.valid_in = v;
    bus.sof      = s;
    bus.din      = d;
    @(posedge clk);
    #1;
    check({tag, ".flags"}, {25'd0, flags()}, {25'd0, exp_flags});
    check({tag, ".dout"}, {24'd0, bus.dout}, {24'd0, exp_d});
    bus.valid_in = 1'b0;
    bus.sof      = 1'b0;
  endtask

  // mask bit j-1 is the hand-computed data/stuff decision for position j.
  task automatic frame(input string tag, input logic [7:0] p, input logic [7:0] c,
                       input int npos, input logic [7:0] mask, input logic [7:0] base,
                       input logic early, input int gap);
    logic first_data;
    logic d;
    first_data = 1'b1;
    for (int j = 1; j <= npos; j++) begin
      if (gap != 0 && j == gap + 1) begin
        for (int g = 0; g < 2; g++)
          step({tag, ".gap"}, 1'b0, 1'b0, 8'hEE, {exp_ds, 6'b0}, exp_dout);
      end
      if (j == 1) begin
        bus.pm = p;
        bus.cm = c;
      end else begin
        bus.pm = 8'hFF;
        bus.cm = 8'h00;
      end
      d = mask[j-1];
      exp_ds = d;
      if (d) exp_dout = base + 8'(j - 1);
      step($sformatf("%s.p%0d", tag, j), 1'b1, (j == 1), base + 8'(j - 1),
           {d, d, d && first_data, (8'(j) == p), early && (j == 1), 2'b00}, exp_dout);
      if (d) first_data = 1'b0;
    end
  endtask

  initial begin
    bus.pm = 8'd0;
    bus.cm = 8'd0;
    bus.valid_in = 1'b0;
    bus.sof = 1'b0;
    bus.din = 8'h00;
    #12;
    check("reset.flags", {25'd0, flags()}, 32'd0);
    check("reset.dout", {24'd0, bus.dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    frame("s1", 8'd8, 8'd3, 8, 8'b1010_0100, 8'h10, 1'b0, 0);

    frame("s2a", 8'd5, 8'd5, 5, 8'b0001_1111, 8'h20, 1'b0, 0);
    frame("s2b", 8'd5, 8'd0, 5, 8'b0000_0000, 8'h30, 1'b0, 0);

    frame("s3", 8'd8, 8'd3, 8, 8'b1010_0100, 8'h40, 1'b0, 4);

    frame("s4a", 8'd8, 8'd3, 4, 8'b0000_0100, 8'h50, 1'b0, 0);
    frame("s4b", 8'd8, 8'd3, 8, 8'b1010_0100, 8'h58, 1'b1, 0);

    frame("s5", 8'd4, 8'd2, 4, 8'b0000_1010, 8'h60, 1'b0, 0);
    step("s5.late", 1'b1, 1'b0, 8'h70, 7'b100_0010, 8'h63);
    bus.pm = 8'd4;
    bus.cm = 8'd6;
    step("s5.cfg", 1'b1, 1'b1, 8'h71, 7'b100_0001, 8'h63);
    step("s5.idle", 1'b1, 1'b0, 8'h72, 7'b100_0010, 8'h63);

    frame("s6", 8'd8, 8'd3, 2, 8'b0000_0000, 8'h80, 1'b0, 0);
    bus.valid_in = 1'b1;
    bus.din = 8'h82;
    #2;
    rst = 1'b1;
    #1;
    check("s6.rst.flags", {25'd0, flags()}, 32'd0);
    check("s6.rst.dout", {24'd0, bus.dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ds = 1'b0;
    step("s6.late", 1'b1, 1'b0, 8'h83, 7'b000_0010, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
